// File: rtl/rsa_pkg.sv
// Shared definitions for the sequential GCD engine: FSM state encoding and
// the default operand width.
package rsa_pkg;

    // Default operand/result width for gcd_seq.
    localparam int GCD_WIDTH = 8;

    // Controller states: waiting for start, subtracting, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : rsa_pkg

// File: rtl/gcd_step.sv
// One compare/subtract step of the subtractive Euclid algorithm.
// The larger operand is reduced by the smaller; equal operands pass through
// unchanged and raise eq. Purely combinational.
module gcd_step #(
    parameter int WIDTH = rsa_pkg::GCD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             eq
);

    // Subtract the smaller operand from the larger; ordering prevents underflow.
    always_comb begin
        next_a = a;
        next_b = b;
        eq     = (a == b);
        if (a > b) begin
            next_a = a - b;
        end else if (b > a) begin
            next_b = b - a;
        end
    end

endmodule : gcd_step

// File: rtl/gcd_seq.sv
// Sequential GCD by repeated subtraction (IDLE -> RUN -> DONE).
// Optional build macro GCD_TIMEOUT_EN: when defined, an operation still in RUN
// with iter_cnt == MAX_ITER ends in DONE with err=1 and out=0. When undefined
// there is no limit logic and RUN ends only when a == b.
// state_dbg mirrors the controller state for observation.
module gcd_seq
    import rsa_pkg::*;
#(
    parameter int          WIDTH    = GCD_WIDTH,
    parameter int unsigned MAX_ITER = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             coprime,
    output logic             err,
    output logic [WIDTH-1:0] iter_cnt,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] out_q, iter_cnt_q;
    logic             busy_q, done_q, err_q, coprime_q;

    logic [WIDTH-1:0] a_d, b_d, iter_cnt_d;
    logic             eq_d;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_q),
        .b      (b_q),
        .next_a (a_d),
        .next_b (b_d),
        .eq     (eq_d)
    );

    // Step counter increments but sticks at all-ones instead of wrapping.
    always_comb begin
        iter_cnt_d = (iter_cnt_q == {WIDTH{1'b1}}) ? iter_cnt_q : iter_cnt_q + ONE;
    end

    // Controller FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            iter_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            coprime_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q        <= A;
                        b_q        <= B;
                        iter_cnt_q <= '0;
                        if ((A == '0) || (B == '0)) begin
                            // Zero operand has no GCD here: report an error at once.
                            out_q     <= '0;
                            err_q     <= 1'b1;
                            coprime_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef GCD_TIMEOUT_EN
                    if (iter_cnt_q == MAX_ITER[WIDTH-1:0]) begin
                        out_q     <= '0;
                        err_q     <= 1'b1;
                        coprime_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else
`endif
                    if (eq_d) begin
                        out_q     <= a_q;
                        err_q     <= 1'b0;
                        coprime_q <= (a_q == ONE);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        a_q        <= a_d;
                        b_q        <= b_d;
                        iter_cnt_q <= iter_cnt_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign coprime   = coprime_q;
    assign err       = err_q;
    assign iter_cnt  = iter_cnt_q;
    assign state_dbg = state_q;

endmodule : gcd_seq

// File: doc/gcd_seq.md
GCD_SEQ -- requirements
Module: gcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result bit width.
REQ-002 SHALL have parameter MAX_ITER, default 128, giving the subtract-step limit; it is used only under GCD_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to compute; sampled only in IDLE.
REQ-006 SHALL have ports A and B, input, WIDTH bits each: the operands, captured on the start-sampling edge.
REQ-007 SHALL have port busy, output, 1 bit: high in RUN.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port out, output, WIDTH bits: the GCD, held from done until the next accepted start.
REQ-010 SHALL have port coprime, output, 1 bit: out==1 and err==0, updated together with out.
REQ-011 SHALL have port err, output, 1 bit: zero operand or timeout, held like out.
REQ-012 SHALL have port iter_cnt, output, WIDTH bits: subtract steps performed in the current or last operation.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL capture A and B into registers a and b, clear iter_cnt and go to RUN.
REQ-015 IDLE with start=1 and either operand zero SHALL instead go directly to DONE with out=0, err=1 and coprime=0.
REQ-016 In RUN, on each edge: if a>b then a<=a-b; if b>a then b<=b-a; in both cases iter_cnt increments by 1.
REQ-017 In RUN with a==b, the edge SHALL load out<=a, set err=0, set coprime=(a==1) and go to DONE.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-019 Latency: with N subtract steps, done SHALL be high after edge N+1 counted from the start-sampling edge; for the zero-operand case, done SHALL be high directly after the start-sampling edge.
REQ-020 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-021 start held high SHALL begin a new operation on the first IDLE edge after DONE.
REQ-022 A and B changing during RUN SHALL have no effect on the operation in progress.
REQ-023 Subtraction SHALL be unsigned WIDTH-bit; operand ordering guarantees no underflow.
REQ-024 iter_cnt SHALL saturate at its all-ones value and never wrap.
REQ-025 out, err, coprime and iter_cnt SHALL NOT change except in the transitions defined in REQ-014 through REQ-017 and REQ-030.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, regardless of clk and of the current state.
REQ-027 rst=1 SHALL immediately clear a, b, out, iter_cnt, busy, done, err and coprime to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-029 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro GCD_TIMEOUT_EN defined: a RUN cycle with iter_cnt==MAX_ITER SHALL go to DONE with err=1, out=0 and coprime=0, performing no further subtract.
REQ-031 Macro GCD_TIMEOUT_EN undefined: SHALL have no limit logic; RUN ends only on a==b, worst case 2^WIDTH-2 steps.

Structure
REQ-032 State encoding (IDLE/RUN/DONE typedef) and the default WIDTH constant SHALL live in shared package rsa_pkg.
REQ-033 The one-step compare/subtract SHALL be sub-module gcd_step.
- Inputs: a, b.
- Outputs: next_a, next_b, eq.
- Purely combinational.
REQ-034 gcd_seq SHALL hold all registers and the FSM.

Verification
REQ-035 A=12, B=8, start pulse: out=4, iter_cnt=2, coprime=0, err=0, done high after edge 3.
REQ-036 A=35, B=12: out=1, iter_cnt=13, coprime=1, done high after edge 14.
REQ-037 A=0, B=7: done high after edge 0, out=0, err=1, busy never high.
REQ-038 A=255, B=1: without macro, out=1 and iter_cnt=254; with GCD_TIMEOUT_EN and MAX_ITER=100, err=1, out=0, iter_cnt=100.
REQ-039 rst pulsed 3 cycles into A=35, B=12: all outputs 0 immediately with no done; then A=9, B=6 returns out=3.
REQ-040 start re-pulsed with A=5, B=5 during busy: ignored, original result returned; start held high gives back-to-back operations with one IDLE cycle between.
